edu_gpu_mem_arbiter: RTL

- Round-robin arbiter that shares one data-memory port (port 0 of the GPU data RAM) among NUM_CH GPU core request channels.
- Serves one outstanding transaction at a time and returns a one-cycle ready pulse to the granted channel.
- Bounds every transaction with a timeout, so a silent memory cannot hang a core.
- Sits between the cores' LSU request/ready signals and the GPU memory block.

---
 rtl/edu_gpu_mem_pkg.sv | 30 +++
 rtl/edu_gpu_rr_picker.sv | 30 +++
 rtl/edu_gpu_mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/edu_gpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edu_gpu_mem_pkg
// Brief    : Shared types and helpers for the GPU data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package edu_gpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edu_gpu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : edu_gpu_rr_picker
// Brief    : Returns the first set request bit at or after ptr, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module edu_gpu_rr_picker
  import edu_gpu_mem_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic              any,
  output logic [PTR_W-1:0]  idx
);

  // Scan from the farthest offset down so the nearest requester wins;
  // PTR_W-bit addition wraps because NUM_CH is a power of two.
  always_comb begin
    any = |req;
    idx = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[ptr + PTR_W'(i)]) idx = ptr + PTR_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/edu_gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edu_gpu_mem_arbiter
// Brief    : Round-robin arbiter sharing one data-memory port among NUM_CH
//            core channels, one transaction at a time, with a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module edu_gpu_mem_arbiter
  import edu_gpu_mem_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            ch_read_valid,
  input  logic [NUM_CH-1:0]            ch_write_valid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_raddr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_waddr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]            ch_read_ready,
  output logic [NUM_CH-1:0]            ch_write_ready,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic                         ch_err,
  output logic                         mem_read_valid,
  output logic                         mem_write_valid,
  output logic [ADDR_WIDTH-1:0]        mem_raddr,
  output logic [ADDR_WIDTH-1:0]        mem_waddr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_read_ready,
  input  logic                         mem_write_ready,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         busy,
  output logic [clog2(NUM_CH)-1:0]     grant_id
);

  localparam int c_id_w  = clog2(NUM_CH);
  localparam int c_cnt_w = clog2(TIMEOUT_CYCLES);
  localparam logic [c_id_w-1:0]  c_id_one   = c_id_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  state_e               r_state;
  state_e               w_next_state;
  op_e                  r_op;
  logic [c_id_w-1:0]    r_ptr;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [NUM_CH-1:0]    w_req;
  logic                 w_any;
  logic [c_id_w-1:0]    w_idx;
  logic                 w_wr_sel;
  logic                 w_done;
  logic                 w_tmo;

  assign w_req    = ch_read_valid | ch_write_valid;
  assign w_wr_sel = ch_write_valid[w_idx];
  // Only the ready matching the latched op completes; the other is ignored.
  assign w_done   = (r_op == OP_WRITE) ? mem_write_ready : mem_read_ready;
  assign w_tmo    = (r_cnt == c_tmo_last);
  assign busy     = (r_state != ST_IDLE);

  edu_gpu_rr_picker #(
    .NUM_CH (NUM_CH),
    .PTR_W  (c_id_w)
  ) u_picker (
    .req (w_req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next_state = ST_GRANT;
      ST_GRANT: if (w_done || w_tmo) w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op            <= OP_READ;
      r_ptr           <= '0;
      r_cnt           <= '0;
      grant_id        <= '0;
      ch_read_ready   <= '0;
      ch_write_ready  <= '0;
      ch_rdata        <= '0;
      ch_err          <= 1'b0;
      mem_read_valid  <= 1'b0;
      mem_write_valid <= 1'b0;
      mem_raddr       <= '0;
      mem_waddr       <= '0;
      mem_wdata       <= '0;
    end else begin
      ch_read_ready  <= '0;
      ch_write_ready <= '0;
      ch_err         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            grant_id        <= w_idx;
            r_op            <= w_wr_sel ? OP_WRITE : OP_READ;
            mem_write_valid <= w_wr_sel;
            mem_read_valid  <= !w_wr_sel;
            r_cnt           <= '0;
            if (w_wr_sel) begin
              mem_waddr <= ch_waddr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
              mem_wdata <= ch_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
              mem_raddr <= ch_raddr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            end
          end
        end
        ST_GRANT: begin
          if (w_done || w_tmo) begin
            // Ready pulses are registered here so they are high during RESP.
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            ch_err          <= !w_done;
            if (r_op == OP_WRITE) begin
              ch_write_ready[grant_id] <= 1'b1;
            end else begin
              ch_read_ready[grant_id] <= 1'b1;
              ch_rdata                <= w_done ? mem_rdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_RESP: begin
          r_ptr <= grant_id + c_id_one;
          r_cnt <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire
